// File: rtl/game_pkg.sv
// Shared definitions for the breakout game blocks: state encodings and
// the wall / lives / miss-line defaults used by the sequencer, ball and VGA logic.
package game_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_PLAY     = 3'd1,
    GS_LOST     = 3'd2,
    GS_READY    = 3'd3,
    GS_GAMEOVER = 3'd4,
    GS_WIN      = 3'd5
  } game_state_e;

  localparam int         DEF_NUM_BRICKS  = 12;
  localparam int         DEF_START_LIVES = 3;
  localparam logic [9:0] DEF_MISS_Y      = 10'd470;

endpackage

// File: rtl/frame_pause_timer.sv
// Counts frame ticks while not cleared; done is high on the tick that
// brings the count to PAUSE_FRAMES, so the caller sees it one clk later.
module frame_pause_timer #(
  parameter int PAUSE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic frame_tick,
  output logic done
);

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_FRAMES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: hold at zero while cleared, wrap back to zero on completion
  always_comb begin
    done    = frame_tick & ~clear & (count_q == LAST);
    count_d = count_q;
    if (clear || done) begin
      count_d = '0;
    end else if (frame_tick) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Tick counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer: owns the game FSM, the lives / score / brick
// counters and the control strobes that drive the ball/brick datapath.
module game_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_BRICKS   = DEF_NUM_BRICKS,
  parameter int         START_LIVES  = DEF_START_LIVES,
  parameter logic [9:0] MISS_Y       = DEF_MISS_Y,
  parameter logic [7:0] POINTS       = 8'd10,
  parameter int         PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve_btn,
  input  logic [9:0] ball_y,
  input  logic       brick_hit,
  output logic       ball_reset,
  output logic       ball_relaunch,
  output logic       ball_step,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [3:0] bricks_left,
  output logic [2:0] state,
  output logic       sound_miss
);

  localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
  localparam logic [3:0] BRICKS_INIT = 4'(NUM_BRICKS);

  game_state_e state_q, state_d;
  logic        serve_q, serve_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  bricks_q, bricks_d;
  logic        sound_miss_q, sound_miss_d;

  logic serve_edge;
  logic hit_ok;
  logic wall_clear;
  logic miss;
  logic pause_clear;
  logic pause_done;

  // Score add that pins at 255 instead of wrapping
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Pause timer runs only while in LOST, so it restarts from zero on every entry
  assign pause_clear = (state_q != GS_LOST);

  frame_pause_timer #(
    .PAUSE_FRAMES(PAUSE_FRAMES)
  ) u_pause (
    .clk       (clk),
    .reset     (reset),
    .clear     (pause_clear),
    .frame_tick(frame_tick),
    .done      (pause_done)
  );

  // Play-field event decode; a hit that empties the wall takes priority over a miss
  always_comb begin
    serve_d    = serve_btn;
    serve_edge = serve_btn & ~serve_q;
    hit_ok     = brick_hit && (bricks_q != 4'd0);
    wall_clear = hit_ok && (bricks_q == 4'd1);
    miss       = (ball_y >= MISS_Y);
  end

  // Game state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_IDLE: begin
        if (serve_edge) state_d = GS_PLAY;
      end
      GS_PLAY: begin
        if (wall_clear) begin
          state_d = GS_WIN;
        end else if (miss) begin
          state_d = (lives_q <= 2'd1) ? GS_GAMEOVER : GS_LOST;
        end
      end
      GS_LOST: begin
        if (pause_done) state_d = GS_READY;
      end
      GS_READY: begin
        if (serve_edge) state_d = GS_PLAY;
      end
      GS_GAMEOVER, GS_WIN: begin
        if (serve_edge) state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
  end

  // Datapath strobes decoded from the registered state; step is gated live by frame_tick
  always_comb begin
    ball_reset    = 1'b0;
    ball_relaunch = 1'b0;
    ball_step     = 1'b0;
    case (state_q)
      GS_IDLE:           ball_reset    = 1'b1;
      GS_PLAY:           ball_step     = frame_tick;
      GS_LOST, GS_READY: ball_relaunch = 1'b1;
      default: ;
    endcase
  end

  // Counter updates: reload on a fresh game, hit/miss accounting in PLAY, frozen elsewhere
  always_comb begin
    lives_d      = lives_q;
    score_d      = score_q;
    bricks_d     = bricks_q;
    sound_miss_d = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (serve_edge) begin
          lives_d  = LIVES_INIT;
          score_d  = 8'd0;
          bricks_d = BRICKS_INIT;
        end
      end
      GS_PLAY: begin
        if (hit_ok) begin
          bricks_d = bricks_q - 4'd1;
          score_d  = sat_add(score_q, POINTS);
        end
        if (miss && !wall_clear) begin
          sound_miss_d = 1'b1;
          lives_d      = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
        end
      end
      default: ;
    endcase
  end

  // Counter, serve-history and sound registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serve_q      <= 1'b0;
      lives_q      <= LIVES_INIT;
      score_q      <= 8'd0;
      bricks_q     <= BRICKS_INIT;
      sound_miss_q <= 1'b0;
    end else begin
      serve_q      <= serve_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      bricks_q     <= bricks_d;
      sound_miss_q <= sound_miss_d;
    end
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign bricks_left = bricks_q;
  assign sound_miss  = sound_miss_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: each driven cycle pushes the expected
// post-edge outputs from a behavioural model; they are popped and compared
// after the clock edge. A second instance with large POINTS covers saturation.
module tb_game_ctrl;

  localparam int         NB   = 12;
  localparam int         SL   = 3;
  localparam int         PTS  = 10;
  localparam int         PF   = 60;
  localparam logic [9:0] MY   = 10'd470;
  localparam logic [9:0] Y_OK = 10'd100;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       serve_btn;
  logic [9:0] ball_y;
  logic       brick_hit;

  logic       ball_reset, ball_relaunch, ball_step, sound_miss;
  logic [1:0] lives;
  logic [7:0] score;
  logic [3:0] bricks_left;
  logic [2:0] state;

  logic       ball_reset_s, ball_relaunch_s, ball_step_s, sound_miss_s;
  logic [1:0] lives_s;
  logic [7:0] score_s;
  logic [3:0] bricks_left_s;
  logic [2:0] state_s;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve_btn(serve_btn),
    .ball_y(ball_y), .brick_hit(brick_hit), .ball_reset(ball_reset),
    .ball_relaunch(ball_relaunch), .ball_step(ball_step), .lives(lives),
    .score(score), .bricks_left(bricks_left), .state(state), .sound_miss(sound_miss)
  );

  game_ctrl #(.POINTS(8'd40)) dut_sat (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve_btn(serve_btn),
    .ball_y(ball_y), .brick_hit(brick_hit), .ball_reset(ball_reset_s),
    .ball_relaunch(ball_relaunch_s), .ball_step(ball_step_s), .lives(lives_s),
    .score(score_s), .bricks_left(bricks_left_s), .state(state_s), .sound_miss(sound_miss_s)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lives;
    logic [7:0] score;
    logic [3:0] bricks;
    logic       snd;
    logic       brst;
    logic       brl;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int   m_state, m_lives, m_score, m_bricks, m_pause;
  logic m_serve, m_snd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs
  task automatic model_clk(input logic sv, input logic tk, input logic hit, input logic [9:0] y);
    logic sedge;
    int   ns, nl, nsc, nb, np;
    logic nm;
    sedge = sv && !m_serve;
    ns = m_state; nl = m_lives; nsc = m_score; nb = m_bricks; np = m_pause; nm = 1'b0;
    case (m_state)
      0: if (sedge) begin ns = 1; nl = SL; nsc = 0; nb = NB; end
      1: begin
        if (hit && m_bricks > 0) begin
          nb  = m_bricks - 1;
          nsc = (m_score + PTS > 255) ? 255 : m_score + PTS;
        end
        if (hit && m_bricks == 1) ns = 5;
        else if (y >= MY) begin
          nm = 1'b1;
          nl = m_lives - 1;
          ns = (m_lives == 1) ? 4 : 2;
        end
      end
      2: if (tk) begin np = m_pause + 1; if (np == PF) ns = 3; end
      3: if (sedge) ns = 1;
      4, 5: if (sedge) ns = 0;
      default: ns = 0;
    endcase
    if (ns != 2) np = 0;
    m_state = ns; m_lives = nl; m_score = nsc; m_bricks = nb; m_pause = np;
    m_snd = nm; m_serve = sv;
  endtask

  task automatic step(input logic sv, input logic tk, input logic hit, input logic [9:0] y);
    exp_t e;
    serve_btn = sv; frame_tick = tk; brick_hit = hit; ball_y = y;
    #1;
    chk("ball_step", 32'(ball_step), 32'(tk && (m_state == 1)));
    model_clk(sv, tk, hit, y);
    e.st     = 3'(m_state);
    e.lives  = 2'(m_lives);
    e.score  = 8'(m_score);
    e.bricks = 4'(m_bricks);
    e.snd    = m_snd;
    e.brst   = (m_state == 0);
    e.brl    = (m_state == 2) || (m_state == 3);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state",         32'(state),         32'(e.st));
    chk("lives",         32'(lives),         32'(e.lives));
    chk("score",         32'(score),         32'(e.score));
    chk("bricks_left",   32'(bricks_left),   32'(e.bricks));
    chk("sound_miss",    32'(sound_miss),    32'(e.snd));
    chk("ball_reset",    32'(ball_reset),    32'(e.brst));
    chk("ball_relaunch", 32'(ball_relaunch), 32'(e.brl));
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b1; serve_btn = 1'b0; brick_hit = 1'b0; ball_y = Y_OK;
    #1;
    chk("rst_state",    32'(state),         32'd0);
    chk("rst_lives",    32'(lives),         32'd3);
    chk("rst_score",    32'(score),         32'd0);
    chk("rst_bricks",   32'(bricks_left),   32'd12);
    chk("rst_breset",   32'(ball_reset),    32'd1);
    chk("rst_relaunch", 32'(ball_relaunch), 32'd0);
    chk("rst_step",     32'(ball_step),     32'd0);
    chk("rst_sound",    32'(sound_miss),    32'd0);
    m_state = 0; m_lives = SL; m_score = 0; m_bricks = NB; m_pause = 0;
    m_serve = 1'b0; m_snd = 1'b0;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_state", 32'(state), 32'd0);
    reset = 1'b0;
  endtask

  task automatic serve_pulse();
    step(1'b1, 1'b0, 1'b0, Y_OK);
    step(1'b0, 1'b0, 1'b0, Y_OK);
  endtask

  task automatic hit_n(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b1, Y_OK);
      step(1'b0, 1'b1, 1'b0, Y_OK);
    end
  endtask

  // Sit out the LOST pause (with a stray hit and serve that must be ignored), then serve
  task automatic lost_to_play();
    for (int t = 0; t < PF; t++) begin
      if (t == PF - 1) chk("lost_hold", 32'(state), 32'd2);
      step(t == 10, 1'b1, t == 5, Y_OK);
      step(1'b0, 1'b0, 1'b0, Y_OK);
    end
    chk("ready_state", 32'(state), 32'd3);
    step(1'b1, 1'b0, 1'b0, Y_OK);
    chk("ready_to_play", 32'(state), 32'd1);
    chk("relaunch_drop", 32'(ball_relaunch), 32'd0);
    step(1'b0, 1'b0, 1'b0, Y_OK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int entries;
    logic [2:0] prev;
    do_reset();

    // Held serve: exactly one IDLE->PLAY transition
    entries = 0;
    prev = state;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, (i % 4) == 3, 1'b0, Y_OK);
      if (state == 3'd1 && prev != 3'd1) entries++;
      prev = state;
    end
    chk("serve_once", 32'(entries), 32'd1);
    step(1'b0, 1'b0, 1'b0, Y_OK);

    // Clear the wall
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b1, Y_OK);
      if (k == 12) begin
        chk("win_state",  32'(state),       32'd5);
        chk("win_score",  32'(score),       32'd120);
        chk("win_bricks", 32'(bricks_left), 32'd0);
      end
      step(1'b0, 1'b1, 1'b0, Y_OK);
    end
    step(1'b0, 1'b0, 1'b1, Y_OK);
    chk("hit13_score", 32'(score), 32'd120);
    step(1'b1, 1'b0, 1'b0, Y_OK);
    chk("win_to_idle", 32'(state), 32'd0);
    step(1'b0, 1'b0, 1'b0, Y_OK);

    // Miss with lives=3, pause, relaunch keeps bricks
    serve_pulse();
    hit_n(2);
    step(1'b0, 1'b0, 1'b0, MY);
    chk("miss_sound",    32'(sound_miss),    32'd1);
    chk("miss_lives",    32'(lives),         32'd2);
    chk("miss_state",    32'(state),         32'd2);
    chk("miss_relaunch", 32'(ball_relaunch), 32'd1);
    step(1'b0, 1'b0, 1'b0, Y_OK);
    chk("miss_sound_end", 32'(sound_miss), 32'd0);
    lost_to_play();
    chk("relaunch_bricks", 32'(bricks_left), 32'd10);

    // Down to the last life, then game over
    step(1'b0, 1'b0, 1'b0, MY);
    step(1'b0, 1'b0, 1'b0, Y_OK);
    lost_to_play();
    chk("last_life", 32'(lives), 32'd1);
    step(1'b0, 1'b0, 1'b0, 10'd475);
    chk("go_state", 32'(state), 32'd4);
    chk("go_lives", 32'(lives), 32'd0);
    step(1'b0, 1'b1, 1'b0, Y_OK);
    step(1'b1, 1'b0, 1'b0, Y_OK);
    chk("go_to_idle", 32'(state), 32'd0);
    step(1'b0, 1'b0, 1'b0, Y_OK);

    // Reset in the middle of play
    serve_pulse();
    hit_n(4);
    step(1'b0, 1'b0, 1'b0, MY);
    step(1'b0, 1'b0, 1'b0, Y_OK);
    lost_to_play();
    chk("pre_rst_score", 32'(score), 32'd40);
    chk("pre_rst_lives", 32'(lives), 32'd2);
    do_reset();

    // Last brick and miss in the same cycle: WIN, no life lost
    serve_pulse();
    hit_n(11);
    step(1'b0, 1'b0, 1'b1, 10'd480);
    chk("tie_state", 32'(state),      32'd5);
    chk("tie_lives", 32'(lives),      32'd3);
    chk("tie_sound", 32'(sound_miss), 32'd0);
    serve_pulse();

    // Saturation on the high-POINTS instance
    do_reset();
    serve_pulse();
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1, Y_OK);
      chk("sat_score", 32'(score_s), (k * 40 > 255) ? 32'd255 : 32'(k * 40));
      step(1'b0, 1'b0, 1'b0, Y_OK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
